icache_direct_mapped: RTL and testbench

- Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port and the memory controller's instruction port.
- Consumes the fetch request (imemREN/imemaddr) and returns ihit/imemload, which gate every pipeline latch and the PC.
- On a miss it issues one single-word read to memory, fills the line and replays as a hit.
- Keeps hit/miss counters for per-core performance reporting.

---
 rtl/icache_direct_mapped.sv | 166 ++++++++++++++++
 tb/tb_icache_direct_mapped.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct_mapped.sv
// ----------------------------------------------------------------------------
// icache_direct_mapped
//
// Direct-mapped, read-only instruction cache between the datapath fetch port
// and the memory controller instruction port. Each line holds one 32-bit
// word. Hits return data combinationally in the same cycle. A miss issues a
// single-word read, fills the line, and the fetch then replays as a hit.
//
// Ports:
//   CLK        in   rising-edge clock
//   nRST       in   asynchronous active-low reset
//   imemREN    in   fetch request from the datapath
//   imemaddr   in   fetch byte address (bits [1:0] ignored)
//   ihit       out  fetch data valid this cycle
//   imemload   out  fetched instruction, 0 when ihit=0
//   iflush     in   invalidate every line at the next edge
//   iREN       out  memory read request (asserted for the whole miss)
//   iaddr      out  memory word address, 0 when iREN=0
//   iwait      in   memory busy; iREN=1 with iwait=0 returns iload
//   iload      in   memory read data
//   hit_count  out  saturating count of hit cycles
//   miss_count out  saturating count of miss entries
// ----------------------------------------------------------------------------
module icache_direct_mapped #(
    parameter  int SETS  = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    // Per-line storage.
    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    // Miss bookkeeping: word address being fetched and a "drop" flag that
    // keeps a fill invalid when a flush arrived while it was in flight.
    state_t      state_q, state_d;
    logic [31:2] maddr_q, maddr_d;
    logic        drop_q,  drop_d;

    logic [31:0] hit_count_q,  hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Address decode for the incoming fetch and the outstanding miss.
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] midx;
    logic [TAG_W-1:0] mtag;
    logic             hit;
    logic             fill;

    // Byte offset of the fetch address carries no information for a
    // word-granular cache.
    logic unused_byte_offset;
    assign unused_byte_offset = ^imemaddr[1:0];

    assign idx  = imemaddr[IDX_W+1:2];
    assign tag  = imemaddr[31:IDX_W+2];
    assign midx = maddr_q[IDX_W+1:2];
    assign mtag = maddr_q[31:IDX_W+2];

    // Lookup only in IDLE; in MISS the datapath is stalled regardless.
    assign hit  = (state_q == IDLE) && imemREN && valid_q[idx] && (tag_q[idx] == tag);
    assign fill = (state_q == MISS) && !iwait;

    assign ihit       = hit;
    assign imemload   = hit ? data_q[idx] : 32'h0;
    assign iREN       = (state_q == MISS);
    assign iaddr      = iREN ? {maddr_q, 2'b00} : 32'h0;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        maddr_d      = maddr_q;
        drop_d       = drop_q;
        valid_d      = valid_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;

        case (state_q)
            IDLE: begin
                if (imemREN && !hit) begin
                    maddr_d = imemaddr[31:2];
                    state_d = MISS;
                    if (miss_count_q != 32'hFFFF_FFFF) begin
                        miss_count_d = miss_count_q + 32'd1;
                    end
                end
            end
            MISS: begin
                if (!iwait) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q) begin
                        valid_d[midx] = 1'b1;
                    end
                end else if (iflush) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush has the last word, so a fill landing in the same cycle
        // stays invalid.
        if (iflush) begin
            valid_d = '0;
        end

        if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            maddr_q      <= '0;
            drop_q       <= 1'b0;
            valid_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            maddr_q      <= maddr_d;
            drop_q       <= drop_d;
            valid_q      <= valid_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // NOTE: tag and data arrays are deliberately left out of reset; the
    // valid bits alone decide whether their contents are ever used.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[midx]  <= mtag;
            data_q[midx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// ----------------------------------------------------------------------------
// tb_icache_direct_mapped
//
// Cycle-scripted bench for icache_direct_mapped (SETS=16). Each scenario task
// drives one stimulus cycle at a time, pushing the expected outputs for that
// cycle onto a scoreboard queue and the sampled DUT outputs onto a second
// queue; the task then drains both queues and compares them in order.
// Expected hit/miss counters come from a small counter model in cyc().
// ----------------------------------------------------------------------------
module tb_icache_direct_mapped;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    typedef struct packed {
        logic        ihit;
        logic [31:0] load;
        logic        iren;
        logic [31:0] iaddr;
        logic [31:0] hits;
        logic [31:0] misses;
    } obs_t;

    obs_t sb_exp[$];
    obs_t sb_obs[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hits = 0;
    logic [31:0] exp_miss = 0;

    icache_direct_mapped #(.SETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iflush     (iflush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic string fmt(input obs_t v);
        return $sformatf("ihit=%b imemload=%h iREN=%b iaddr=%h hit_count=%0d miss_count=%0d",
                         v.ihit, v.load, v.iren, v.iaddr, v.hits, v.misses);
    endfunction

    // One clock cycle: drive inputs just after the rising edge, push the
    // expected outputs, sample the DUT on the falling edge.
    task automatic cyc(input logic nrst, input logic ren, input logic [31:0] addr,
                       input logic wt, input logic [31:0] ld, input logic fl,
                       input logic e_ihit, input logic [31:0] e_load,
                       input logic e_iren, input logic [31:0] e_iaddr);
        obs_t e;
        obs_t o;
        nRST     = nrst;
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = ld;
        iflush   = fl;
        if (!nrst) begin
            exp_hits = 0;
            exp_miss = 0;
        end
        e.ihit   = e_ihit;
        e.load   = e_load;
        e.iren   = e_iren;
        e.iaddr  = e_iaddr;
        e.hits   = exp_hits;
        e.misses = exp_miss;
        sb_exp.push_back(e);
        // Counter model: counts become visible one cycle after the event.
        if (nrst && e_ihit && exp_hits != 32'hFFFF_FFFF) exp_hits++;
        if (nrst && ren && !e_ihit && !e_iren && exp_miss != 32'hFFFF_FFFF) exp_miss++;
        @(negedge CLK);
        o.ihit   = ihit;
        o.load   = imemload;
        o.iren   = iREN;
        o.iaddr  = iaddr;
        o.hits   = hit_count;
        o.misses = miss_count;
        sb_obs.push_back(o);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        cyc(0, 1, 32'h0, 1, 32'h0, 0,  0, 32'h0, 0, 32'h0);
        cyc(0, 1, 32'h4, 0, 32'h1, 1,  0, 32'h0, 0, 32'h0);
        for (int k = 0; sb_exp.size() != 0; k++) begin
            obs_t e = sb_exp.pop_front();
            obs_t o = sb_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_reset[%0d]: got %s, expected %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 32'(i * 4), 0, 32'hFFFF_0000, 0,  0, 32'h0, 0, 32'h0);
        end
        for (int k = 0; sb_exp.size() != 0; k++) begin
            obs_t e = sb_exp.pop_front();
            obs_t o = sb_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_idle[%0d]: got %s, expected %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_miss_fill;
        cyc(1, 1, 32'h00, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        cyc(1, 0, 32'h10, 1, 32'h0,         0,  0, 32'h0,         1, 32'h0);
        cyc(1, 1, 32'h40, 1, 32'h0,         0,  0, 32'h0,         1, 32'h0);
        cyc(1, 1, 32'h00, 0, 32'h00500093, 0,  0, 32'h0,         1, 32'h0);
        cyc(1, 1, 32'h00, 1, 32'h0,         0,  1, 32'h00500093, 0, 32'h0);
        for (int k = 0; sb_exp.size() != 0; k++) begin
            obs_t e = sb_exp.pop_front();
            obs_t o = sb_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_miss_fill[%0d]: got %s, expected %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_back_to_back;
        cyc(1, 1, 32'h00, 1, 32'h0, 0,  1, 32'h00500093, 0, 32'h0);
        cyc(1, 1, 32'h00, 1, 32'h0, 0,  1, 32'h00500093, 0, 32'h0);
        cyc(1, 1, 32'h03, 1, 32'h0, 0,  1, 32'h00500093, 0, 32'h0);
        cyc(1, 0, 32'h00, 1, 32'h0, 0,  0, 32'h0,         0, 32'h0);
        for (int k = 0; sb_exp.size() != 0; k++) begin
            obs_t e = sb_exp.pop_front();
            obs_t o = sb_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_back_to_back[%0d]: got %s, expected %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_conflict;
        cyc(1, 1, 32'h40, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        cyc(1, 1, 32'h40, 0, 32'hDEADBEEF, 0,  0, 32'h0,         1, 32'h40);
        cyc(1, 1, 32'h40, 1, 32'h0,         0,  1, 32'hDEADBEEF, 0, 32'h0);
        cyc(1, 1, 32'h00, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        cyc(1, 1, 32'h00, 0, 32'h00500093, 0,  0, 32'h0,         1, 32'h0);
        cyc(1, 1, 32'h00, 1, 32'h0,         0,  1, 32'h00500093, 0, 32'h0);
        cyc(1, 1, 32'h04, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        cyc(1, 1, 32'h04, 0, 32'h11111111, 0,  0, 32'h0,         1, 32'h04);
        cyc(1, 1, 32'h04, 1, 32'h0,         0,  1, 32'h11111111, 0, 32'h0);
        cyc(1, 0, 32'h00, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        for (int k = 0; sb_exp.size() != 0; k++) begin
            obs_t e = sb_exp.pop_front();
            obs_t o = sb_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_conflict[%0d]: got %s, expected %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_flush;
        // Hit still served from pre-flush contents.
        cyc(1, 1, 32'h04, 1, 32'h0,         1,  1, 32'h11111111, 0, 32'h0);
        cyc(1, 1, 32'h00, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        cyc(1, 1, 32'h00, 0, 32'h00500093, 0,  0, 32'h0,         1, 32'h0);
        cyc(1, 1, 32'h00, 1, 32'h0,         0,  1, 32'h00500093, 0, 32'h0);
        cyc(1, 1, 32'h04, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        // Flush coincides with fill completion.
        cyc(1, 1, 32'h04, 0, 32'h11111111, 1,  0, 32'h0,         1, 32'h04);
        cyc(1, 1, 32'h04, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        cyc(1, 1, 32'h04, 0, 32'h11111111, 0,  0, 32'h0,         1, 32'h04);
        cyc(1, 1, 32'h04, 1, 32'h0,         0,  1, 32'h11111111, 0, 32'h0);
        // Flush while the fill is still outstanding.
        cyc(1, 1, 32'h08, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        cyc(1, 1, 32'h08, 1, 32'h0,         1,  0, 32'h0,         1, 32'h08);
        cyc(1, 1, 32'h08, 0, 32'h22222222, 0,  0, 32'h0,         1, 32'h08);
        cyc(1, 1, 32'h08, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        cyc(1, 1, 32'h08, 0, 32'h22222222, 0,  0, 32'h0,         1, 32'h08);
        cyc(1, 1, 32'h08, 1, 32'h0,         0,  1, 32'h22222222, 0, 32'h0);
        for (int k = 0; sb_exp.size() != 0; k++) begin
            obs_t e = sb_exp.pop_front();
            obs_t o = sb_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_flush[%0d]: got %s, expected %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_reset_in_miss;
        cyc(1, 1, 32'h0C, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        cyc(1, 1, 32'h0C, 1, 32'h0,         0,  0, 32'h0,         1, 32'h0C);
        cyc(0, 1, 32'h0C, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        // Late memory response after reset must not fill anything.
        cyc(1, 0, 32'h0C, 0, 32'h33333333, 0,  0, 32'h0,         0, 32'h0);
        // Line 0x08 was valid before reset; cache must now be empty.
        cyc(1, 1, 32'h08, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        cyc(1, 1, 32'h08, 0, 32'h22222222, 0,  0, 32'h0,         1, 32'h08);
        cyc(1, 1, 32'h0C, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        cyc(1, 1, 32'h0C, 0, 32'h44444444, 0,  0, 32'h0,         1, 32'h0C);
        cyc(1, 1, 32'h0C, 1, 32'h0,         0,  1, 32'h44444444, 0, 32'h0);
        cyc(1, 0, 32'h00, 1, 32'h0,         0,  0, 32'h0,         0, 32'h0);
        for (int k = 0; sb_exp.size() != 0; k++) begin
            obs_t e = sb_exp.pop_front();
            obs_t o = sb_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL test_reset_in_miss[%0d]: got %s, expected %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        nRST     = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iflush   = 1'b0;
        iwait    = 1'b1;
        iload    = 32'h0;
        #2 nRST  = 1'b0;
        @(posedge CLK);
        #1;
        test_reset;
        test_idle;
        test_miss_fill;
        test_back_to_back;
        test_conflict;
        test_flush;
        test_reset_in_miss;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
